booth_seq_mult: RTL and testbench

BOOTH_SEQ_MULT -- requirements
Module: booth_seq_mult

---
 rtl/booth_seq_mult.sv | 66 ++++++
 tb/tb_booth_seq_mult.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/booth_seq_mult.sv
// booth_seq_mult: sequential radix-2 Booth multiplier, signed or unsigned operands, one step per clock
// Ports:
//   clk, rst_n                  clock (rising edge) and asynchronous active-low reset
//   in_valid, in_ready          operand handshake; accepts a, b, is_signed only in IDLE
//   a, b, is_signed             multiplicand, multiplier, 1 = two's-complement operands
//   out_valid, out_ready        result handshake; product held in DONE until out_ready
//   product                     registered 2*WIDTH-bit exact product
module booth_seq_mult #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH+1:0] acc, m, sum;
    logic [WIDTH:0] q;
    logic q_m1;
    logic [CW-1:0] cnt;
    logic accept, last;
    logic [2*WIDTH+2:0] aq_nx;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        in_ready = state == IDLE;
        out_valid = state == DONE;
        accept = in_ready && in_valid;
        last = state == CALC && cnt == CW'(WIDTH);
        state_nx = accept ? CALC : last ? DONE : (out_valid && out_ready) ? IDLE : state;
    end
    // Booth add/subtract; two guard bits in acc/m keep the most-negative operand exact
    assign sum = (q[0] == q_m1) ? acc : q[0] ? acc - m : acc + m;
    // arithmetic right shift of {A, Q}; Q[0] falls into q_m1
    assign aq_nx = {sum[WIDTH+1], sum, q[WIDTH:1]};
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            acc <= '0;
            m <= '0;
            q <= '0;
            q_m1 <= 1'b0;
            cnt <= '0;
            product <= '0;
        end else if (accept) begin
            acc <= '0;
            m <= {{2{is_signed & a[WIDTH-1]}}, a};
            q <= {is_signed & b[WIDTH-1], b};
            q_m1 <= 1'b0;
            cnt <= '0;
        end else if (state == CALC) begin
            acc <= aq_nx[2*WIDTH+2:WIDTH+1];
            q <= aq_nx[WIDTH:0];
            q_m1 <= q[0];
            cnt <= cnt + CW'(1);
            if (last) product <= aq_nx[2*WIDTH-1:0];
        end
endmodule

// File: tb/tb_booth_seq_mult.sv
// tb_booth_seq_mult: directed vectors, handshake corner cases and random regression for booth_seq_mult
module tb_booth_seq_mult;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic is_signed = 1'b0;
    logic out_valid;
    logic out_ready = 1'b0;
    logic [2*W-1:0] product;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    booth_seq_mult #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid),
        .out_ready(out_ready), .product(product)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic s;
        logic [2*W-1:0] p;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        longint ex, ey;
        ex = s ? longint'($signed(x)) : longint'(x);
        ey = s ? longint'($signed(y)) : longint'(y);
        return (2*W)'(ex * ey);
    endfunction

    task automatic start(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts);
        @(negedge clk);
        a = ta;
        b = tb;
        is_signed = ts;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!out_valid && lat < 200);
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic [2*W-1:0] prev, exp;
        logic bp_ok;
        vecs[0] = '{8'h07, 8'hFD, 1'b1, 16'hFFEB};
        vecs[1] = '{8'h80, 8'h80, 1'b1, 16'h4000};
        vecs[2] = '{8'h80, 8'h7F, 1'b1, 16'hC080};
        vecs[3] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
        vecs[5] = '{8'h03, 8'h05, 1'b0, 16'h000F};
        vecs[6] = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
        vecs[7] = '{8'h00, 8'hFF, 1'b1, 16'h0000};

        #12;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_product", product, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            start(vecs[i].a, vecs[i].b, vecs[i].s);
            wait_valid(lat);
            chk($sformatf("vec%0d_product", i), product, vecs[i].p);
            chk($sformatf("vec%0d_latency", i), lat, 9);
            release_out();
            chk($sformatf("vec%0d_out_valid_drop", i), out_valid, 0);
            chk($sformatf("vec%0d_in_ready_back", i), in_ready, 1);
        end

        // backpressure: result must hold while out_ready stays low
        start(8'h80, 8'h7F, 1'b1);
        wait_valid(lat);
        bp_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!out_valid || product !== 16'hC080 || in_ready) bp_ok = 1'b0;
        end
        chk("backpressure_hold", bp_ok, 1);
        release_out();
        chk("backpressure_out_valid_drop", out_valid, 0);
        chk("backpressure_in_ready", in_ready, 1);

        // inputs during CALC/DONE ignored, including the DONE-to-IDLE handoff edge
        prev = product;
        start(8'h07, 8'hFD, 1'b1);
        @(negedge clk);
        a = 8'h55;
        b = 8'h33;
        is_signed = 1'b0;
        in_valid = 1'b1;
        chk("calc_in_ready_low", in_ready, 0);
        chk("calc_product_held", product, prev);
        wait_valid(lat);
        chk("ignored_product", product, 16'hFFEB);
        chk("ignored_latency", lat, 9);
        release_out();
        chk("handoff_in_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("post_handoff_accept", in_ready, 0);
        wait_valid(lat);
        chk("post_handoff_product", product, 16'h10EF);
        chk("post_handoff_latency", lat, 9);
        release_out();

        // reset during CALC step 4, then first-edge acceptance after release
        start(8'hFF, 8'hFF, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_product", product, 0);
        chk("midreset_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        a = 8'h03;
        b = 8'h05;
        is_signed = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_valid(lat);
        chk("after_reset_product", product, 16'h000F);
        chk("after_reset_latency", lat, 9);
        release_out();

        for (int i = 0; i < 4000; i++) begin
            logic [W-1:0] ra, rb;
            logic rs;
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            exp = model(ra, rb, rs);
            start(ra, rb, rs);
            wait_valid(lat);
            chk($sformatf("rand%0d_product a=%0h b=%0h s=%0d", i, ra, rb, rs), product, exp);
            chk($sformatf("rand%0d_latency", i), lat, 9);
            release_out();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
